// File: rtl/gcd_controller.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// gcd_controller
// Control FSM for a subtractive-Euclid GCD datapath. The datapath holds A and B
// registers, a subtractor feeding each register through a 2:1 mux, a magnitude
// comparator, and a result register. This block steers those muxes/enables.
//
// Ports
//   clk                      rising-edge clock
//   rst                      asynchronous active-low reset
//   start                    request a run (sampled only in IDLE)
//   clear                    synchronous abort back to IDLE
//   a_gt_b/a_eq_b/a_lt_b     comparator flags for the A and B registers
//   a_sel/b_sel              mux select: 1 = external operand, 0 = difference
//   a_ld/b_ld                A/B register load enables
//   output_en                result register load enable
//   busy                     high whenever the FSM is not in IDLE
//   done                     one-cycle completion pulse
//   error                    sticky error (bad flags or iteration timeout)
//   iter_count               subtraction cycles in the current/last run
// -----------------------------------------------------------------------------
module gcd_controller #(
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear,
  input  logic        a_gt_b,
  input  logic        a_eq_b,
  input  logic        a_lt_b,
  output logic        a_sel,
  output logic        b_sel,
  output logic        a_ld,
  output logic        b_ld,
  output logic        output_en,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CALC  = 3'd2,
    S_STORE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [15:0] MaxIter = 16'(MAX_ITER);

  state_t      state_q, state_d;
  logic [15:0] iter_q, iter_d;
  logic        error_q, error_d;

  logic flags_valid;
  logic at_limit;

  // A trustworthy comparator drives exactly one of the three flags.
  assign flags_valid = ({a_gt_b, a_eq_b, a_lt_b} == 3'b100) ||
                       ({a_gt_b, a_eq_b, a_lt_b} == 3'b010) ||
                       ({a_gt_b, a_eq_b, a_lt_b} == 3'b001);
  assign at_limit    = (iter_q == MaxIter);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    iter_d    = iter_q;
    error_d   = error_q;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    a_ld      = 1'b0;
    b_ld      = 1'b0;
    output_en = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        a_sel   = 1'b1;
        b_sel   = 1'b1;
        a_ld    = 1'b1;
        b_ld    = 1'b1;
        iter_d  = '0;
        error_d = 1'b0;
        state_d = S_CALC;
      end
      S_CALC: begin
        // Mealy: enables follow the live comparator flags in the same cycle.
        if (!flags_valid) begin
          state_d = S_ERR;
        end else if (a_eq_b) begin
          state_d = S_STORE;
        end else if (at_limit) begin
          state_d = S_ERR;
        end else if (a_gt_b) begin
          a_ld   = 1'b1;
          iter_d = iter_q + 16'd1;
        end else begin
          b_ld   = 1'b1;
          iter_d = iter_q + 16'd1;
        end
      end
      S_STORE: begin
        output_en = 1'b1;
        state_d   = S_DONE;
      end
      S_ERR: begin
        error_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything except reset; counters and error are frozen.
    if (clear) begin
      state_d   = S_IDLE;
      iter_d    = iter_q;
      error_d   = error_q;
      a_sel     = 1'b0;
      b_sel     = 1'b0;
      a_ld      = 1'b0;
      b_ld      = 1'b0;
      output_en = 1'b0;
      done      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      error_q <= error_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign error      = error_q;
  assign iter_count = iter_q;

endmodule

// File: doc/gcd_controller.md
GCD_CONTROLLER -- requirements
Module: gcd_controller

Interface
REQ-001 Parameter: MAX_ITER, 65535, subtraction-cycle limit before timeout error (1..65535).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a GCD run; sampled only in IDLE.
REQ-005 clear  input  1  synchronous abort; highest priority after rst.
REQ-006 a_gt_b, a_eq_b, a_lt_b  input  1 each  datapath magnitude flags of A and B registers.
REQ-007 a_sel, b_sel  output  1 each  operand mux select: 1 = external input, 0 = difference.
REQ-008 a_ld, b_ld  output  1 each  A/B register load enables.
REQ-009 output_en  output  1  result register load enable.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 error  output  1  sticky error flag.
REQ-013 iter_count  output  16  subtraction cycles in current/last run.

Function
REQ-014 States: IDLE, LOAD, CALC, STORE, DONE, ERR; binary-encoded, one state register.
REQ-015 IDLE: all load enables 0; start=1 -> LOAD; start while not IDLE is ignored (no queuing).
REQ-016 LOAD (1 cycle): a_sel=b_sel=1, a_ld=b_ld=1, iter_count<=0, error<=0; -> CALC.
REQ-017 CALC flags valid = exactly one of gt/eq/lt high; otherwise -> ERR with no load asserted.
REQ-018 CALC, a_eq_b: no loads; -> STORE.
REQ-019 CALC, a_gt_b, iter_count<MAX_ITER: a_sel=0, a_ld=1, iter_count+1; stay CALC.
REQ-020 CALC, a_lt_b, iter_count<MAX_ITER: b_sel=0, b_ld=1, iter_count+1; stay CALC.
REQ-021 CALC, gt or lt with iter_count==MAX_ITER: no loads; -> ERR (timeout).
REQ-022 CALC outputs are Mealy (combinational from state and flags); a_ld and b_ld never high together in CALC.
REQ-023 STORE (1 cycle): output_en=1; -> DONE.
REQ-024 ERR (1 cycle): error<=1, output_en never asserted; -> DONE.
REQ-025 DONE (1 cycle): done=1; -> IDLE; start in DONE ignored.
REQ-026 Latency: start sampled at edge N; done high in cycle N+4+k, k = subtraction count; result register valid from that cycle.
REQ-027 iter_count saturates conceptually at MAX_ITER (timeout fires first); holds value in IDLE until next LOAD.
REQ-028 error holds from ERR until next LOAD or reset; done and error coincide on error runs.
REQ-029 clear=1 in any state: next state IDLE, all enables 0 that cycle, no done pulse; error and iter_count keep values.
REQ-030 a_sel/b_sel default 0 whenever their load enable is 0.

Reset
REQ-031 rst low asynchronously forces IDLE; a_sel, b_sel, a_ld, b_ld, output_en, busy, done, error = 0; iter_count = 0.
REQ-032 Reset mid-run aborts immediately; no done or output_en pulse on or after deassertion until a new start.
REQ-033 First start honoured at the first rising edge with rst high.

Verification (bench pairs controller with a behavioural A/B/compare/result datapath model)
REQ-034 A=12,B=18, start 1 cycle -> b_ld then a_ld, iter_count=2, output_en in cycle N+5, done in N+6, result=6, error=0.
REQ-035 A=7,B=7 -> iter_count=0, done in cycle N+4, result=7; then A=65535,B=1 -> iter_count=65534, result=1, no error.
REQ-036 MAX_ITER=8, A=0,B=5 -> 8 b_ld pulses, then ERR: error=1 with done, output_en never high, iter_count=8.
REQ-037 Force a_gt_b=a_lt_b=1 in CALC -> no load that cycle, error=1, done 2 cycles later; next start clears error.
REQ-038 start pulsed while busy -> ignored, single done; clear asserted in CALC -> IDLE next cycle, no done, busy=0.
REQ-039 rst low mid-CALC (between edges) -> outputs 0 immediately, iter_count=0; after release, new run A=9,B=6 -> result 3.
